// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter/timer with one-shot or auto-reload,
// borrow-out for cascading and a registered done pulse after each terminal count.
module down_counter_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             bout,
    output logic             done,
    output logic             busy
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state;
    logic [WIDTH-1:0] r;
    assign busy = (state == RUN);
    // Combinational so a cascaded upper stage sees its enable in the same cycle.
    assign bout = (state == RUN) && en && (q == '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                r <= in;
                q <= in;
                if (stop)
                    state <= IDLE;
                else if (start)
                    state <= RUN;
            end else if (stop) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                if (start) begin
                    q     <= r;
                    state <= RUN;
                end
            end else if (en) begin
                if (q == '0) begin
                    done <= 1'b1;
                    if (mode)
                        q <= r;
                    else
                        state <= IDLE;
                end else begin
                    q <= q - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: randomized and directed checks of down_counter_timer
// against a cycle-level behavioural model, plus a two-stage cascade.
module tb_down_counter_timer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
    logic [7:0] val = '0;
    logic [7:0] q;
    logic       bout, done, busy;

    logic       c_en = 1'b0, c_load = 1'b0, c_start = 1'b0;
    logic [7:0] c_val = 8'd255;
    logic [7:0] lo_q, up_q;
    logic       lo_bout, up_bout, lo_done, up_done, lo_busy, up_busy;

    int n_cmp = 0, n_bad = 0;
    int m_q, m_r, m_done;
    bit m_run;
    int bout_cnt, done_cnt;

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .in(val), .start(start),
        .stop(stop), .mode(mode), .q(q), .bout(bout), .done(done), .busy(busy));

    down_counter_timer #(.WIDTH(8)) lo (
        .clk(clk), .rst_n(rst_n), .en(c_en), .load(c_load), .in(c_val), .start(c_start),
        .stop(1'b0), .mode(1'b1), .q(lo_q), .bout(lo_bout), .done(lo_done), .busy(lo_busy));

    down_counter_timer #(.WIDTH(8)) up (
        .clk(clk), .rst_n(rst_n), .en(lo_bout), .load(c_load), .in(c_val), .start(c_start),
        .stop(1'b0), .mode(1'b1), .q(up_q), .bout(up_bout), .done(up_done), .busy(up_busy));

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_r = 0; m_run = 0; m_done = 0;
    endtask

    // One clock: drive inputs, check borrow before the edge, then state after it.
    task automatic step(input logic e, input logic l, input logic [7:0] v,
                        input logic s, input logic p, input logic m);
        int exp_bout;
        @(negedge clk);
        en = e; load = l; val = v; start = s; stop = p; mode = m;
        #1;
        exp_bout = (m_run && e && m_q == 0) ? 1 : 0;
        chk("bout", int'(bout), exp_bout);
        bout_cnt += int'(bout);
        @(posedge clk);
        m_done = 0;
        if (l) begin
            m_r = v; m_q = v;
            m_run = p ? 1'b0 : (m_run | s);
        end else if (p) begin
            m_run = 0;
        end else if (!m_run) begin
            if (s) begin m_q = m_r; m_run = 1; end
        end else if (e) begin
            if (m_q == 0) begin
                m_done = 1;
                if (m) m_q = m_r; else m_run = 0;
            end else begin
                m_q = m_q - 1;
            end
        end
        #1;
        chk("q", int'(q), m_q);
        chk("busy", int'(busy), int'(m_run));
        chk("done", int'(done), m_done);
        done_cnt += int'(done);
    endtask

    task automatic cstep(input logic e, input logic l, input logic s);
        @(negedge clk);
        c_en = e; c_load = l; c_start = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_bout", int'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot from 3
        step(1, 1, 8'd3, 0, 0, 0);
        step(1, 0, 8'd0, 1, 0, 0);
        chk("os_start_q", int'(q), 3);
        bout_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 5; i++) step(1, 0, 8'd0, 0, 0, 0);
        chk("os_bouts", bout_cnt, 1);
        chk("os_dones", done_cnt, 1);
        chk("os_end_q", int'(q), 0);
        chk("os_end_busy", int'(busy), 0);

        // Auto-reload from 2 over 9 enabled cycles
        step(0, 1, 8'd2, 0, 0, 1);
        step(0, 0, 8'd0, 1, 0, 1);
        bout_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 9; i++) step(1, 0, 8'd0, 0, 0, 1);
        chk("ar_bouts", bout_cnt, 3);
        chk("ar_dones", done_cnt, 3);
        chk("ar_q", int'(q), 2);

        // Enable gating from 255
        step(0, 1, 8'd255, 1, 0, 1);
        for (int i = 0; i < 10; i++) step(1'(i % 2 == 0), 0, 8'd0, 0, 0, 1);
        chk("gate_q", int'(q), 250);

        // Load at terminal wins
        step(0, 1, 8'd1, 0, 0, 1);
        step(1, 0, 8'd0, 0, 0, 1);
        chk("pri_q0", int'(q), 0);
        step(1, 1, 8'd7, 0, 0, 1);
        chk("pri_load_q", int'(q), 7);
        chk("pri_load_done", int'(done), 0);
        chk("pri_load_busy", int'(busy), 1);
        step(1, 1, 8'd9, 0, 1, 1);
        chk("pri_ldstop_q", int'(q), 9);
        chk("pri_ldstop_busy", int'(busy), 0);
        step(0, 1, 8'd10, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'd0, 0, 0, 0);
        step(1, 0, 8'd0, 0, 1, 0);
        chk("stop_q", int'(q), 5);
        chk("stop_busy", int'(busy), 0);

        // Start in IDLE with en low: Q takes R, holds
        step(0, 0, 8'd0, 1, 0, 0);
        step(0, 0, 8'd0, 0, 0, 0);
        chk("idle_start_q", int'(q), 10);
        chk("idle_start_busy", int'(busy), 1);
        step(1, 0, 8'd0, 1, 0, 0);
        chk("run_start_ign", int'(q), 9);

        // Reload of zero: borrow every enabled cycle
        step(0, 1, 8'd0, 0, 1, 1);
        step(0, 0, 8'd0, 1, 0, 1);
        bout_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 6; i++) step(1'(i != 3), 0, 8'd0, 0, 0, 1);
        chk("zero_bouts", bout_cnt, 5);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
                 8'($urandom_range(0, 6)), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 3) != 0));

        // Asynchronous reset mid-count
        step(1, 1, 8'd50, 1, 0, 1);
        step(1, 0, 8'd0, 0, 0, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_q", int'(q), 0);
        chk("areset_busy", int'(busy), 0);
        chk("areset_done", int'(done), 0);
        chk("areset_bout", int'(bout), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Cascade: upper stage decrements once per 256 lower enabled cycles
        cstep(0, 1, 0);
        cstep(0, 0, 1);
        cstep(1, 0, 0);
        chk("casc_lo1", int'(lo_q), 254);
        chk("casc_up1", int'(up_q), 255);
        for (int i = 1; i < 256; i++) cstep(1, 0, 0);
        chk("casc_lo256", int'(lo_q), 255);
        chk("casc_up256", int'(up_q), 254);
        for (int i = 0; i < 256; i++) cstep(1'(1), 0, 0);
        chk("casc_lo512", int'(lo_q), 255);
        chk("casc_up512", int'(up_q), 253);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
